// File: rtl/fp16_div_iter.sv
// Iterative binary16 divider: restoring radix-2 mantissa division, fixed 14-edge latency,
// valid/ready on both sides. Zero/underflow flush to +0, overflow saturates to 0x7FFF magnitude.
module fp16_div_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] data_1_i,
    input  logic [15:0] data_2_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] data_div_o,
    output logic        div_by_zero_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               sign_q;
    logic               za_q;
    logic               zb_q;
    logic signed [6:0]  exp_q;
    logic [10:0]        ma_q;
    logic [10:0]        mb_q;
    logic [12:0]        rem_q;
    logic [11:0]        quo_q;
    logic [3:0]         cnt_q;
    logic               ready_q;
    logic               valid_q;
    logic               dbz_q;
    logic [15:0]        res_q;

    logic [12:0]        mb_ext;
    logic               qbit;
    logic [12:0]        rem_sub;
    logic [12:0]        rem_d;
    logic [11:0]        mant_rnd;
    logic [15:0]        res_d;

    // Round half up on the guard bit; a carry lands in bit 11 with bits 10:0 cleared.
    function automatic logic [11:0] round_half_up(input logic [11:0] q);
        return {1'b0, q[11:1]} + {11'd0, q[0]};
    endfunction

    function automatic logic [15:0] pack_result(
        input logic              s,
        input logic              za,
        input logic              zb,
        input logic signed [6:0] e,
        input logic [11:0]       m
    );
        logic signed [6:0] e_r;
        e_r = m[11] ? e + 7'sd1 : e;
        if (zb)
            return {s, 15'h7FFF};
        if (za)
            return 16'h0000;
        if (e_r <= 7'sd0)
            return 16'h0000;
        if (e_r > 7'sd31)
            return {s, 15'h7FFF};
        return {s, e_r[4:0], m[9:0]};
    endfunction

    assign mb_ext   = {2'b00, mb_q};
    assign qbit     = (rem_q >= mb_ext);
    assign rem_sub  = qbit ? (rem_q - mb_ext) : rem_q;
    assign rem_d    = {rem_sub[11:0], 1'b0};
    assign mant_rnd = round_half_up(quo_q);
    assign res_d    = pack_result(sign_q, za_q, zb_q, exp_q, mant_rnd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
            exp_q   <= 7'sd0;
            ma_q    <= 11'd0;
            mb_q    <= 11'd0;
            rem_q   <= 13'd0;
            quo_q   <= 12'd0;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            res_q   <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i && ready_q) begin
                        sign_q  <= data_1_i[15] ^ data_2_i[15];
                        za_q    <= (data_1_i[14:0] == 15'd0);
                        zb_q    <= (data_2_i[14:0] == 15'd0);
                        exp_q   <= $signed({2'b00, data_1_i[14:10]})
                                 - $signed({2'b00, data_2_i[14:10]}) + 7'sd15;
                        ma_q    <= {1'b1, data_1_i[9:0]};
                        mb_q    <= {1'b1, data_2_i[9:0]};
                        ready_q <= 1'b0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Pre-normalise so the first quotient bit is always 1.
                    if (ma_q < mb_q) begin
                        rem_q <= {1'b0, ma_q, 1'b0};
                        exp_q <= exp_q - 7'sd1;
                    end else begin
                        rem_q <= {2'b00, ma_q};
                    end
                    quo_q   <= 12'd0;
                    cnt_q   <= 4'd0;
                    state_q <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[10:0], qbit};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd11)
                        state_q <= S_ROUND;
                end
                S_ROUND: begin
                    res_q   <= res_d;
                    dbz_q   <= zb_q;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign valid_o       = valid_q;
    assign data_div_o    = res_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fp16_div_iter.sv
// Scoreboard bench for fp16_div_iter: directed cases, backpressure, mid-operation reset
// and randomized operands checked against an arithmetic reference model.
module tb_fp16_div_iter;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_1_i;
    logic [15:0] data_2_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] data_div_o;
    logic        div_by_zero_o;

    int total = 0;
    int bad   = 0;
    logic [16:0] sb[$];

    fp16_div_iter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_1_i     (data_1_i),
        .data_2_i     (data_2_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_div_o   (data_div_o),
        .div_by_zero_o(div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endfunction

    // Reference: exact integer quotient scaled to 12 bits, then round half up.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, e, ma, mb, q, m;
        logic s;
        s = a[15] ^ b[15];
        if (b[14:0] == 15'd0) return {1'b1, s, 15'h7FFF};
        if (a[14:0] == 15'd0) return 17'h0;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = 1024 + int'(a[9:0]);
        mb = 1024 + int'(b[9:0]);
        e  = ea - eb + 15;
        if (ma >= mb) begin
            q = (ma * 2048) / mb;
        end else begin
            q = (ma * 4096) / mb;
            e = e - 1;
        end
        m = q / 2 + q % 2;
        if (m == 2048) begin
            m = 1024;
            e = e + 1;
        end
        if (e <= 0) return 17'h0;
        if (e > 31) return {1'b0, s, 15'h7FFF};
        return {1'b0, s, e[4:0], m[9:0]};
    endfunction

    // Monitor: a result is consumed at the next edge whenever valid_o and ready_i are both high.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {15'd0, div_by_zero_o, data_div_o}, 32'h1FFFF);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("result", {15'd0, div_by_zero_o, data_div_o}, {15'd0, e});
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] expv, input int hold);
        int n;
        int lat;
        logic [15:0] d;
        logic dz;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_before_op", {31'd0, ready_o}, 32'd1);
        valid_i  = 1'b1;
        data_1_i = a;
        data_2_i = b;
        sb.push_back(expv);
        @(posedge clk); #1;
        chk("ready_low_after_accept", {31'd0, ready_o}, 32'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            valid_i  = 1'($urandom_range(0, 1));
            data_1_i = 16'($urandom);
            data_2_i = 16'($urandom);
            @(posedge clk); #1;
            lat++;
            if (valid_o) break;
        end
        valid_i = 1'b0;
        chk("latency", lat, 32'd14);
        d  = data_div_o;
        dz = div_by_zero_o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, valid_o}, 32'd1);
            chk("hold_data", {15'd0, div_by_zero_o, data_div_o}, {15'd0, dz, d});
            chk("hold_ready_low", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk("valid_low_after_consume", {31'd0, valid_o}, 32'd0);
        chk("ready_high_after_consume", {31'd0, ready_o}, 32'd1);
    endtask

    logic [15:0] dir_a[11] = '{16'h4600, 16'h3C00, 16'h4500, 16'hC500, 16'h3C00, 16'hBC00,
                              16'h0000, 16'h8000, 16'h7800, 16'h0400, 16'h7BFF};
    logic [15:0] dir_b[11] = '{16'h4000, 16'h4200, 16'h4200, 16'h4200, 16'h0000, 16'h8000,
                              16'h0000, 16'h4000, 16'h0400, 16'h7800, 16'h3C00};
    logic [16:0] dir_e[11] = '{17'h04200, 17'h03555, 17'h03EAB, 17'h0BEAB, 17'h17FFF, 17'h17FFF,
                              17'h17FFF, 17'h00000, 17'h07FFF, 17'h00000, 17'h07BFF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_1_i = 16'h0;
        data_2_i = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_data", {16'd0, data_div_o}, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero_o}, 32'd0);

        for (int i = 0; i < 11; i++)
            run_op(dir_a[i], dir_b[i], dir_e[i], 0);

        run_op(16'h4600, 16'h4000, 17'h04200, 5);

        // Abort mid-divide: reset sampled at E6, nothing may be emitted.
        valid_i  = 1'b1;
        data_1_i = 16'h4600;
        data_2_i = 16'h4000;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_valid", {31'd0, valid_o}, 32'd0);
        chk("abort_data", {16'd0, data_div_o}, 32'd0);
        run_op(16'h4600, 16'h4000, 17'h04200, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                end
                1: begin
                    a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                    b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                end
                2: begin
                    a = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
                    b = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
                end
                default: begin
                    a = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
                    b = {1'($urandom), 15'd0};
                    if ($urandom_range(0, 1) == 1) begin
                        b = a ^ 16'h0400;
                        a = {1'($urandom), 15'd0};
                    end
                end
            endcase
            run_op(a, b, model(a, b), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
